// File: rtl/k_mips_pkg.sv
// k_mips_pkg: shared MIPS encodings (ALU ops, opcodes, functs, mux selects, control states).
package k_mips_pkg;
  localparam logic [3:0] ALU_AND = 4'b0000, ALU_OR = 4'b0001, ALU_ADD = 4'b0010,
                         ALU_SUB = 4'b0110, ALU_SLT = 4'b0111, ALU_SLL = 4'b1000;
  localparam logic [5:0] OP_RTYPE = 6'h00, OP_J = 6'h02, OP_BEQ = 6'h04,
                         OP_ADDI = 6'h08, OP_LW = 6'h23, OP_SW = 6'h2B;
  localparam logic [5:0] FN_SLL = 6'h00, FN_ADD = 6'h20, FN_SUB = 6'h22,
                         FN_AND = 6'h24, FN_OR = 6'h25, FN_SLT = 6'h2A;
  localparam logic [1:0] SRCB_B = 2'b00, SRCB_FOUR = 2'b01, SRCB_IMM = 2'b10, SRCB_IMM_SH2 = 2'b11;
  localparam logic [1:0] PCSRC_ALU = 2'b00, PCSRC_ALUOUT = 2'b01, PCSRC_JUMP = 2'b10;
  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEM_ADDR, S_MEM_RD, S_MEM_WB, S_MEM_WR,
    S_R_EXEC, S_R_WB, S_ADDI_EXEC, S_ADDI_WB, S_BRANCH, S_JUMP
  } state_t;
  typedef enum logic [1:0] {AC_ADD, AC_SUB, AC_FUNCT} alu_class_t;
endpackage

// File: rtl/k_alu_decoder.sv
// k_alu_decoder: maps (state class, funct) to ALU operation, shift-amount select and funct validity.
module k_alu_decoder
  import k_mips_pkg::*;
(
  input  alu_class_t  alu_class,
  input  logic [5:0]  funct,
  output logic [3:0]  alu_control,
  output logic        shamt_sel,
  output logic        funct_valid
);
  logic [3:0] funct_op;
  always_comb begin
    funct_valid = 1'b1;
    funct_op = ALU_ADD;
    case (funct)
      FN_ADD: funct_op = ALU_ADD;
      FN_SUB: funct_op = ALU_SUB;
      FN_AND: funct_op = ALU_AND;
      FN_OR:  funct_op = ALU_OR;
      FN_SLT: funct_op = ALU_SLT;
      FN_SLL: funct_op = ALU_SLL;
      default: funct_valid = 1'b0;
    endcase
  end
  assign alu_control = alu_class == AC_FUNCT ? funct_op : alu_class == AC_SUB ? ALU_SUB : ALU_ADD;
  assign shamt_sel = alu_class == AC_FUNCT && funct == FN_SLL;
endmodule

// File: rtl/k_mc_control.sv
// k_mc_control: multicycle MIPS control FSM sequencing datapath muxes, strobes and ALU operation.
module k_mc_control
  import k_mips_pkg::*;
#(
  parameter bit K_ADDR_CHECK = 1'b1
) (
  input  logic       K_clk,
  input  logic       K_rst_n,
  input  logic [5:0] K_opcode,
  input  logic [5:0] K_funct,
  input  logic       K_zero,
  input  logic       K_mem_ready,
  output logic [3:0] K_ALU_control,
  output logic       K_alu_src_a,
  output logic [1:0] K_alu_src_b,
  output logic       K_shamt_sel,
  output logic       K_iord,
  output logic       K_mem_read,
  output logic       K_mem_write,
  output logic       K_ir_write,
  output logic       K_pc_en,
  output logic [1:0] K_pc_source,
  output logic       K_reg_write,
  output logic       K_reg_dst,
  output logic       K_mem_to_reg,
  output logic       K_retire,
  output logic       K_illegal
);
  state_t     state;
  alu_class_t alu_class;
  logic       funct_valid, is_mem, op_valid, bad;
  assign is_mem = K_opcode == OP_LW || K_opcode == OP_SW;
  assign op_valid = is_mem || K_opcode inside {OP_RTYPE, OP_ADDI, OP_BEQ, OP_J};
  // Unknown opcodes and unknown R-type functs both fall back to FETCH as a NOP.
  assign bad = !op_valid || (K_opcode == OP_RTYPE && !funct_valid);
  assign alu_class = state == S_R_EXEC ? AC_FUNCT : state == S_BRANCH ? AC_SUB : AC_ADD;
  k_alu_decoder u_alu_decoder (
    .alu_class   (alu_class),
    .funct       (K_funct),
    .alu_control (K_ALU_control),
    .shamt_sel   (K_shamt_sel),
    .funct_valid (funct_valid)
  );
  always_ff @(posedge K_clk)
    if (!K_rst_n) state <= S_FETCH;
    else
      case (state)
        S_FETCH:     if (K_mem_ready) state <= S_DECODE;
        S_DECODE:    state <= bad ? S_FETCH : is_mem ? S_MEM_ADDR : K_opcode == OP_RTYPE ? S_R_EXEC :
                              K_opcode == OP_ADDI ? S_ADDI_EXEC : K_opcode == OP_BEQ ? S_BRANCH : S_JUMP;
        S_MEM_ADDR:  state <= K_opcode == OP_LW ? S_MEM_RD : S_MEM_WR;
        S_MEM_RD:    if (K_mem_ready) state <= S_MEM_WB;
        S_MEM_WR:    if (K_mem_ready) state <= S_FETCH;
        S_R_EXEC:    state <= S_R_WB;
        S_ADDI_EXEC: state <= S_ADDI_WB;
        default:     state <= S_FETCH;
      endcase
  assign K_alu_src_a = state inside {S_MEM_ADDR, S_R_EXEC, S_ADDI_EXEC, S_BRANCH};
  assign K_alu_src_b = state == S_FETCH ? SRCB_FOUR : state == S_DECODE ? SRCB_IMM_SH2 :
                       state inside {S_MEM_ADDR, S_ADDI_EXEC} ? SRCB_IMM : SRCB_B;
  assign K_iord = state inside {S_MEM_RD, S_MEM_WR};
  assign K_mem_read = state inside {S_FETCH, S_MEM_RD};
  assign K_mem_write = state == S_MEM_WR;
  assign K_ir_write = state == S_FETCH && K_mem_ready;
  assign K_pc_en = (state == S_FETCH && K_mem_ready) || state == S_JUMP || (state == S_BRANCH && K_zero);
  assign K_pc_source = state == S_BRANCH ? PCSRC_ALUOUT : state == S_JUMP ? PCSRC_JUMP : PCSRC_ALU;
  assign K_reg_write = state inside {S_MEM_WB, S_R_WB, S_ADDI_WB};
  assign K_reg_dst = state == S_R_WB;
  assign K_mem_to_reg = state == S_MEM_WB;
  assign K_retire = state inside {S_MEM_WB, S_R_WB, S_ADDI_WB, S_BRANCH, S_JUMP} ||
                    (state == S_MEM_WR && K_mem_ready);
  assign K_illegal = K_ADDR_CHECK && state == S_DECODE && bad;
endmodule

// File: tb/tb_k_mc_control.sv
// tb_k_mc_control: per-instruction cycle-sequence model checked against k_mc_control outputs.
module tb_k_mc_control;
  typedef struct packed {
    logic [3:0] alu;
    logic       src_a;
    logic [1:0] src_b;
    logic       shamt, iord, mem_read, mem_write, ir_write, pc_en;
    logic [1:0] pc_source;
    logic       reg_write, reg_dst, mem_to_reg, retire, illegal;
  } outs_t;
  typedef struct packed {
    logic  ready;
    logic  zero;
    outs_t exp;
  } step_t;
  logic K_clk = 1'b0, K_rst_n = 1'b0, K_zero = 1'b0, K_mem_ready = 1'b0;
  logic [5:0] K_opcode = '0, K_funct = '0;
  logic [3:0] K_ALU_control;
  logic [1:0] K_alu_src_b, K_pc_source;
  logic K_alu_src_a, K_shamt_sel, K_iord, K_mem_read, K_mem_write, K_ir_write, K_pc_en;
  logic K_reg_write, K_reg_dst, K_mem_to_reg, K_retire, K_illegal;
  outs_t obs;
  int errors = 0, checks = 0;
  step_t q[$];

  k_mc_control #(.K_ADDR_CHECK(1'b1)) dut (
    .K_clk(K_clk), .K_rst_n(K_rst_n), .K_opcode(K_opcode), .K_funct(K_funct),
    .K_zero(K_zero), .K_mem_ready(K_mem_ready), .K_ALU_control(K_ALU_control),
    .K_alu_src_a(K_alu_src_a), .K_alu_src_b(K_alu_src_b), .K_shamt_sel(K_shamt_sel),
    .K_iord(K_iord), .K_mem_read(K_mem_read), .K_mem_write(K_mem_write),
    .K_ir_write(K_ir_write), .K_pc_en(K_pc_en), .K_pc_source(K_pc_source),
    .K_reg_write(K_reg_write), .K_reg_dst(K_reg_dst), .K_mem_to_reg(K_mem_to_reg),
    .K_retire(K_retire), .K_illegal(K_illegal)
  );

  always #5 K_clk = ~K_clk;
  assign obs = {K_ALU_control, K_alu_src_a, K_alu_src_b, K_shamt_sel, K_iord, K_mem_read,
                K_mem_write, K_ir_write, K_pc_en, K_pc_source, K_reg_write, K_reg_dst,
                K_mem_to_reg, K_retire, K_illegal};

  function automatic outs_t dflt();
    outs_t o = '0;
    o.alu = 4'b0010;
    return o;
  endfunction

  function automatic outs_t fetch_idle();
    outs_t o = dflt();
    o.mem_read = 1'b1;
    o.src_b = 2'b01;
    return o;
  endfunction

  function automatic bit known_op(input logic [5:0] op);
    return op inside {6'h00, 6'h02, 6'h04, 6'h08, 6'h23, 6'h2B};
  endfunction

  // Returns {valid, alu op} for an R-type funct.
  function automatic logic [4:0] rt_map(input logic [5:0] fn);
    case (fn)
      6'h20: return {1'b1, 4'b0010};
      6'h22: return {1'b1, 4'b0110};
      6'h24: return {1'b1, 4'b0000};
      6'h25: return {1'b1, 4'b0001};
      6'h2A: return {1'b1, 4'b0111};
      6'h00: return {1'b1, 4'b1000};
      default: return 5'b0;
    endcase
  endfunction

  function automatic logic rb();
    return 1'($urandom_range(0, 1));
  endfunction

  task automatic push(input outs_t o, input logic rdy, input logic z);
    step_t s;
    s.exp = o;
    s.ready = rdy;
    s.zero = z;
    q.push_back(s);
  endtask

  task automatic step(input string tag, input int idx, input step_t s);
    K_mem_ready = s.ready;
    K_zero = s.zero;
    #1;
    checks++;
    assert (obs === s.exp) else begin
      errors++;
      $error("FAIL %s step%0d obs=%h exp=%h", tag, idx, obs, s.exp);
    end
    @(posedge K_clk);
    #1;
  endtask

  task automatic run_instr(input string tag, input logic [5:0] op, input logic [5:0] fn,
                           input int wf, input int wm, input logic z);
    outs_t o;
    logic [4:0] rt;
    bit bad;
    rt = rt_map(fn);
    bad = !known_op(op) || (op == 6'h00 && !rt[4]);
    K_opcode = op;
    K_funct = fn;
    q.delete();
    o = fetch_idle();
    for (int i = 0; i < wf; i++) push(o, 1'b0, rb());
    o.ir_write = 1'b1;
    o.pc_en = 1'b1;
    push(o, 1'b1, rb());
    o = dflt();
    o.src_b = 2'b11;
    o.illegal = bad;
    push(o, rb(), rb());
    if (!bad)
      case (op)
        6'h23, 6'h2B: begin
          o = dflt(); o.src_a = 1'b1; o.src_b = 2'b10; push(o, rb(), rb());
          o = dflt(); o.iord = 1'b1;
          if (op == 6'h23) o.mem_read = 1'b1; else o.mem_write = 1'b1;
          for (int i = 0; i < wm; i++) push(o, 1'b0, rb());
          if (op == 6'h2B) o.retire = 1'b1;
          push(o, 1'b1, rb());
          if (op == 6'h23) begin
            o = dflt(); o.reg_write = 1'b1; o.mem_to_reg = 1'b1; o.retire = 1'b1;
            push(o, rb(), rb());
          end
        end
        6'h00: begin
          o = dflt(); o.src_a = 1'b1; o.alu = rt[3:0]; o.shamt = (fn == 6'h00); push(o, rb(), rb());
          o = dflt(); o.reg_write = 1'b1; o.reg_dst = 1'b1; o.retire = 1'b1; push(o, rb(), rb());
        end
        6'h08: begin
          o = dflt(); o.src_a = 1'b1; o.src_b = 2'b10; push(o, rb(), rb());
          o = dflt(); o.reg_write = 1'b1; o.retire = 1'b1; push(o, rb(), rb());
        end
        6'h04: begin
          o = dflt(); o.alu = 4'b0110; o.src_a = 1'b1; o.pc_source = 2'b01;
          o.pc_en = z; o.retire = 1'b1; push(o, rb(), z);
        end
        default: begin
          o = dflt(); o.pc_source = 2'b10; o.pc_en = 1'b1; o.retire = 1'b1; push(o, rb(), rb());
        end
      endcase
    for (int i = 0; i < q.size(); i++) step(tag, i, q[i]);
  endtask

  initial begin
    step_t s;
    outs_t o;
    logic [5:0] op, fn;
    logic [5:0] goods [6] = '{6'h23, 6'h2B, 6'h00, 6'h08, 6'h04, 6'h02};
    logic [5:0] fns [6] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A, 6'h00};
    repeat (2) @(posedge K_clk);
    #1;
    K_rst_n = 1'b1;
    step("reset", 0, '{1'b0, 1'b0, fetch_idle()});
    run_instr("sub", 6'h00, 6'h22, 0, 0, 1'b0);
    run_instr("sll", 6'h00, 6'h00, 0, 0, 1'b0);
    run_instr("lw_wait", 6'h23, 6'h11, 0, 3, 1'b0);
    run_instr("beq_z1", 6'h04, 6'h05, 0, 0, 1'b1);
    run_instr("beq_z0", 6'h04, 6'h05, 0, 0, 1'b0);
    run_instr("bad_op", 6'h3F, 6'h20, 0, 0, 1'b0);
    run_instr("bad_fn", 6'h00, 6'h3F, 0, 0, 1'b0);
    run_instr("addi", 6'h08, 6'h3F, 1, 0, 1'b0);
    run_instr("sw", 6'h2B, 6'h00, 0, 2, 1'b0);
    run_instr("jump", 6'h02, 6'h22, 2, 0, 1'b1);
    // Reset while an lw is stalled in the memory-read wait.
    K_opcode = 6'h23;
    o = fetch_idle(); o.ir_write = 1'b1; o.pc_en = 1'b1;
    step("rst_lw", 0, '{1'b1, 1'b0, o});
    o = dflt(); o.src_b = 2'b11;
    step("rst_lw", 1, '{1'b1, 1'b0, o});
    o = dflt(); o.src_a = 1'b1; o.src_b = 2'b10;
    step("rst_lw", 2, '{1'b1, 1'b0, o});
    o = dflt(); o.iord = 1'b1; o.mem_read = 1'b1;
    step("rst_lw", 3, '{1'b0, 1'b0, o});
    K_rst_n = 1'b0;
    K_mem_ready = 1'b0;
    @(posedge K_clk);
    #1;
    K_rst_n = 1'b1;
    s = '{1'b0, 1'b0, fetch_idle()};
    step("rst_fetch", 0, s);
    for (int n = 0; n < 60; n++) begin
      int kind;
      kind = int'($urandom_range(0, 7));
      fn = 6'($urandom_range(0, 63));
      if (kind < 6) op = goods[kind];
      else if (kind == 6) begin
        do op = 6'($urandom_range(0, 63)); while (known_op(op));
      end else begin
        op = 6'h00;
        do fn = 6'($urandom_range(0, 63)); while (rt_map(fn) != 5'b0);
      end
      if (op == 6'h00 && kind == 2) fn = fns[$urandom_range(0, 5)];
      run_instr("rand", op, fn, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), rb());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
